// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
// The optional leading-zero suppression in seg7_scan_ctrl is enabled by LEADING_ZERO_BLANK_EN.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scanState_e;

    // Never returns less than 1 so every counter keeps at least one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_bcd7.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_bcd7 (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank with tear-free word updates.
// Define LEADING_ZERO_BLANK_EN to suppress digits above the most-significant nonzero nibble.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int CNT_W = clog2(SCAN_DIV);
    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam scanState_e       SLOT_FIRST = (BLANK_CYC > 0) ? S_BLANK : S_DRIVE;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    scanState_e              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   dispDp_q, dispDp_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadowDp_q, shadowDp_d;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frameStart_q, frameStart_d;

    logic       slotEnd;
    logic       commitEvent;
    logic       suppress;
    logic [3:0] curNibble;
    logic       curDp;
    logic [6:0] decodedSeg;

    assign slotEnd     = (cnt_q == CNT_LAST);
    assign commitEvent = slotEnd && (idx_q == IDX_LAST);
    assign curNibble   = disp_q[4*idx_q +: 4];
    assign curDp       = dispDp_q[idx_q];

    seg7_bcd7 u_bcd7 (
        .nibble_i (curNibble),
        .seg_o    (decodedSeg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msDigit;

    // Digit 0 is the floor so an all-zero word still shows a single "0".
    always_comb begin
        msDigit = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) begin
                msDigit = IDX_W'(i);
            end
        end
    end

    assign suppress = (idx_q > msDigit);
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        cnt_d   = slotEnd ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        state_d = state_q;
        if (slotEnd) begin
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            state_d = SLOT_FIRST;
        end else begin
            case (state_q)
                S_BLANK: if (cnt_q == BLANK_LAST) state_d = S_DRIVE;
                S_DRIVE: state_d = S_DRIVE;
                default: state_d = S_BLANK;
            endcase
        end
    end

    // A pending word keeps din_ready low, so commit and capture never coincide.
    always_comb begin
        disp_d     = disp_q;
        dispDp_d   = dispDp_q;
        shadow_d   = shadow_q;
        shadowDp_d = shadowDp_q;
        pending_d  = pending_q;
        if (commitEvent && pending_q) begin
            disp_d    = shadow_q;
            dispDp_d  = shadowDp_q;
            pending_d = 1'b0;
        end else if (din_valid && !pending_q) begin
            shadow_d   = din;
            shadowDp_d = dp_in;
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        an_d         = '1;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        frameStart_d = commitEvent;
        if (state_q == S_DRIVE && !suppress) begin
            an_d[idx_q] = 1'b0;
            seg_d       = decodedSeg;
            dp_d        = ~curDp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= S_BLANK;
            disp_q       <= '0;
            dispDp_q     <= '0;
            shadow_q     <= '0;
            shadowDp_q   <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frameStart_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            disp_q       <= disp_d;
            dispDp_q     <= dispDp_d;
            shadow_q     <= shadow_d;
            shadowDp_q   <= shadowDp_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign din_ready   = ~pending_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frameStart_q;

endmodule
